// File: rtl/wvb_writer.sv
// Waveform buffer write side: pre-trigger delay line plus a capture FSM that frames
// one waveform into the data FIFO and one header into the header FIFO per trigger.
module wvb_writer #(
    parameter int unsigned P_WVB_DEPTH = 4096,
    parameter int unsigned P_PRE_MAX   = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] adc_in,
    input  logic [7:0]  discr_in,
    input  logic [47:0] ltc_in,
    input  logic        trig_in,
    input  logic [1:0]  trig_src,
    input  logic [4:0]  pre_conf,
    input  logic [7:0]  post_conf,
    input  logic        trig_mode,
    input  logic        arm,
    input  logic [15:0] wvb_wused,
    input  logic        hdr_full,
    output logic        wvb_wrreq,
    output logic [21:0] wvb_data,
    output logic        hdr_wrreq,
    output logic [79:0] hdr_data,
    output logic        armed,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned SMP_W  = 20;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned LTC_W  = 48;
    localparam int unsigned PRE_W  = 5;
    localparam int unsigned FILL_W = 17;
    localparam int unsigned TAPS   = P_PRE_MAX + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t             state_q;
    logic [PRE_W-1:0]   pre_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               wvb_wrreq_q;
    logic [21:0]        wvb_data_q;
    logic               hdr_wrreq_q;
    logic [79:0]        hdr_data_q;
    logic               armed_q;
    logic               overflow_q;
    logic               busy_q;

    logic [SMP_W-1:0]   dline_q [P_PRE_MAX];
    logic [SMP_W-1:0]   taps_c  [TAPS];
    logic [SMP_W-1:0]   sample_c;
    logic [SMP_W-1:0]   tap_c;
    logic [PRE_W-1:0]   pre_sel_c;
    logic [LEN_W-1:0]   len_c;
    logic               fits_c;
    logic               accept_c;
    logic               more_c;
    logic               last_c;

    assign sample_c = {discr_in, adc_in};

    // History shift register; runs freely, including through reset.
    always_ff @(posedge clk) begin
        dline_q[0] <= sample_c;
        for (int i = 1; i < int'(P_PRE_MAX); i++) begin
            dline_q[i] <= dline_q[i-1];
        end
    end

    // Tap 0 is the live sample so pre=0 needs no extra delay.
    always_comb begin
        taps_c[0] = sample_c;
        for (int i = 1; i < int'(TAPS); i++) begin
            taps_c[i] = dline_q[i-1];
        end
    end

    // Word 0 is loaded on the trigger edge, before pre_q holds the latched value.
    assign pre_sel_c = (state_q == ST_ARMED) ? pre_conf : pre_q;
    assign tap_c     = taps_c[pre_sel_c];

    assign len_c    = LEN_W'(pre_conf) + LEN_W'(post_conf) + LEN_W'(1);
    assign fits_c   = (FILL_W'(wvb_wused) + FILL_W'(len_c)) <= FILL_W'(P_WVB_DEPTH);
    assign accept_c = fits_c && !hdr_full;
    assign more_c   = (cnt_q != len_q);
    assign last_c   = (cnt_q == (len_q - LEN_W'(1)));

    // Capture FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wvb_wrreq_q <= 1'b0;
            wvb_data_q  <= '0;
            hdr_wrreq_q <= 1'b0;
            hdr_data_q  <= '0;
            armed_q     <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wvb_wrreq_q <= 1'b0;
            hdr_wrreq_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (arm) begin
                        state_q <= ST_ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trig_in) begin
                        if (accept_c) begin
                            state_q     <= ST_CAPTURE;
                            pre_q       <= pre_conf;
                            len_q       <= len_c;
                            cnt_q       <= LEN_W'(1);
                            busy_q      <= 1'b1;
                            wvb_wrreq_q <= 1'b1;
                            wvb_data_q  <= {1'b1, (len_c == LEN_W'(1)), tap_c};
                            hdr_wrreq_q <= (len_c == LEN_W'(1));
                            hdr_data_q  <= {ltc_in - LTC_W'(pre_conf), len_c, trig_src, 18'd0};
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (more_c) begin
                        wvb_wrreq_q <= 1'b1;
                        wvb_data_q  <= {1'b0, last_c, tap_c};
                        hdr_wrreq_q <= last_c;
                        cnt_q       <= cnt_q + LEN_W'(1);
                    end else begin
                        // Last word is on the bus this cycle; this is the dead cycle.
                        busy_q <= 1'b0;
                        if (trig_mode) begin
                            state_q <= ST_IDLE;
                            armed_q <= 1'b0;
                        end else begin
                            state_q <= ST_ARMED;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    armed_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wvb_wrreq = wvb_wrreq_q;
    assign wvb_data  = wvb_data_q;
    assign hdr_wrreq = hdr_wrreq_q;
    assign hdr_data  = hdr_data_q;
    assign armed     = armed_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule
